// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the FIFO-fed UART transmitter.
// Imported by the bit timer and the transmitter top level.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled.
// bit_end flags the last clk of every serial bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = enable & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO onto a UART line, LSB first, with
// optional parity and one or two stop bits, no inter-frame gap.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       tx_enable,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD       = 1'(PARITY_ODD);

  tx_state_t  state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic       par_acc;
  logic       bit_end;
  logic       stop_last;
  logic       pop;

  assign busy      = (state != IDLE);
  assign stop_last = (state == STOP) & bit_end
                   & (stop_cnt == LAST_STOP);
  // Pop either from idle or in the final stop cycle (seamless).
  assign pop = rst_n & tx_enable & ~fifo_empty
             & ((state == IDLE) | stop_last);

  assign fifo_rd_en = pop;
  assign frame_done = stop_last;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (pop),
    .enable (busy),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= LINE_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      par_acc   <= 1'b0;
    end else if (pop) begin
      state     <= START;
      tx        <= START_LVL;
      shift_reg <= fifo_data;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      par_acc   <= 1'b0;
    end else if (bit_end) begin
      unique case (state)
        START: begin
          state <= DATA;
          tx    <= shift_reg[0];
        end
        DATA: begin
          par_acc   <= par_acc ^ shift_reg[0];
          shift_reg <= {1'b0, shift_reg[7:1]};
          if (bit_idx == LAST_BIT) begin
            stop_cnt <= 1'b0;
            if (PARITY_EN != 0) begin
              state <= PARITY;
              tx    <= par_acc ^ shift_reg[0] ^ ODD;
            end else begin
              state <= STOP;
              tx    <= LINE_IDLE;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= shift_reg[1];
          end
        end
        PARITY: begin
          state    <= STOP;
          tx       <= LINE_IDLE;
          stop_cnt <= 1'b0;
        end
        STOP: begin
          if (stop_last) begin
            state <= IDLE;
            tx    <= LINE_IDLE;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: four transmitter configurations fed from queue
// FIFOs, each cycle compared against a per-frame waveform model.
module tb_fifo_uart_tx;

  localparam int N = 4;
  localparam int CPB  [N] = '{4, 4, 3, 2};
  localparam int PEN  [N] = '{0, 0, 1, 1};
  localparam int PODD [N] = '{0, 0, 0, 1};
  localparam int STOPB[N] = '{1, 2, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable = 1'b1;
  logic [7:0] fdata [N];
  logic       fempty[N];
  logic       rd_w  [N];
  logic       tx_w  [N];
  logic       busy_w[N];
  logic       done_w[N];

  byte unsigned fq[N][$];
  logic [2:0]   wq[N][$];
  int vectors = 0;
  int misc = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB[0]), .PARITY_EN(PEN[0]),
    .PARITY_ODD(PODD[0]), .STOP_BITS(STOPB[0])) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fdata[0]),
    .fifo_empty(fempty[0]), .fifo_rd_en(rd_w[0]),
    .tx_enable(tx_enable), .tx(tx_w[0]), .busy(busy_w[0]),
    .frame_done(done_w[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB[1]), .PARITY_EN(PEN[1]),
    .PARITY_ODD(PODD[1]), .STOP_BITS(STOPB[1])) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fdata[1]),
    .fifo_empty(fempty[1]), .fifo_rd_en(rd_w[1]),
    .tx_enable(tx_enable), .tx(tx_w[1]), .busy(busy_w[1]),
    .frame_done(done_w[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB[2]), .PARITY_EN(PEN[2]),
    .PARITY_ODD(PODD[2]), .STOP_BITS(STOPB[2])) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fdata[2]),
    .fifo_empty(fempty[2]), .fifo_rd_en(rd_w[2]),
    .tx_enable(tx_enable), .tx(tx_w[2]), .busy(busy_w[2]),
    .frame_done(done_w[2]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB[3]), .PARITY_EN(PEN[3]),
    .PARITY_ODD(PODD[3]), .STOP_BITS(STOPB[3])) dut3 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fdata[3]),
    .fifo_empty(fempty[3]), .fifo_rd_en(rd_w[3]),
    .tx_enable(tx_enable), .tx(tx_w[3]), .busy(busy_w[3]),
    .frame_done(done_w[3]));

  function automatic void refresh(int i);
    fempty[i] = (fq[i].size() == 0);
    fdata[i]  = fempty[i] ? 8'h00 : fq[i][0];
  endfunction

  // Expected line per cycle: {tx, busy, frame_done}.
  function automatic void push_frame(int i, logic [7:0] b);
    logic lv[$];
    lv.push_back(1'b0);
    for (int k = 0; k < 8; k++) lv.push_back(b[k]);
    if (PEN[i] != 0) lv.push_back((^b) ^ PODD[i][0]);
    for (int s = 0; s < STOPB[i]; s++) lv.push_back(1'b1);
    for (int l = 0; l < lv.size(); l++)
      for (int c = 0; c < CPB[i]; c++)
        wq[i].push_back({lv[l], 1'b1,
          (l == lv.size() - 1) && (c == CPB[i] - 1)});
  endfunction

  function automatic void push_byte(logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      fq[i].push_back(b);
      refresh(i);
    end
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (fq[i].size() != 0 || wq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int max_fill();
    int m = 0;
    for (int i = 0; i < N; i++)
      if (fq[i].size() > m) m = fq[i].size();
    return m;
  endfunction

  // Pop side: on each accepted pop, queue the full expected frame.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_w[i] === 1'b1 && fq[i].size() != 0)
        push_frame(i, fq[i].pop_front());
    end
    #1;
    for (int i = 0; i < N; i++) refresh(i);
  end

  // Monitor: line free means no frame cycles remain after this one.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [3:0] e;
      logic [3:0] a;
      if (!rst_n) begin
        wq[i].delete();
        e = 4'b1000;
      end else begin
        e[3:1] = (wq[i].size() > 0) ? wq[i].pop_front() : 3'b100;
        e[0] = tx_enable && (fq[i].size() != 0) && (wq[i].size() == 0);
      end
      a = {tx_w[i], busy_w[i], done_w[i], rd_w[i]};
      vectors++;
      if (a !== e) begin
        misc++;
        $display("FAIL line%0d t=%0t {tx,busy,done,rd} got %b exp %b",
                 i, $time, a, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (!all_idle()) begin
      misc++;
      $display("FAIL drain timeout got busy exp idle after %0d", n);
    end
    repeat (3) step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) refresh(i);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    push_byte(8'hA5);
    wait_idle(500);
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h07);
    wait_idle(1000);

    repeat (100) step();

    push_byte(8'h3C);
    push_byte(8'hC3);
    push_byte(8'h81);
    push_byte(8'h5A);
    repeat (10) step();
    tx_enable = 1'b0;
    repeat (150) step();
    tx_enable = 1'b1;
    wait_idle(2000);

    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 9) < 3 && max_fill() < 16)
        push_byte(8'($urandom));
      if ($urandom_range(0, 99) == 0) tx_enable = ~tx_enable;
    end
    tx_enable = 1'b1;
    wait_idle(4000);

    push_byte(8'h96);
    push_byte(8'h69);
    begin
      int n = 0;
      while (rd_w[0] !== 1'b1 && n < 100) begin
        @(posedge clk);
        n++;
      end
    end
    repeat (18) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({tx_w[i], busy_w[i], done_w[i], rd_w[i]} !== 4'b1000) begin
        misc++;
        $display("FAIL async_rst%0d got %b exp 1000", i,
                 {tx_w[i], busy_w[i], done_w[i], rd_w[i]});
      end
    end
    repeat (3) step();
    rst_n = 1'b1;
    wait_idle(1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the byte FIFO and drives a UART-style line. It sits directly downstream of the 16-entry byte FIFO. It pops one byte whenever the FIFO is non-empty and the line is free, then shifts that byte out LSB-first with start, optional parity and stop bits. There is no idle gap between back-to-back bytes.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- fifo_data  in  8  head-of-FIFO byte; combinational from the FIFO and valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe; one cycle per byte.
- tx_enable  in  1  permits new frames to start.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse in the last cycle of each frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: fifo_rd_en = rst_n & tx_enable & ~fifo_empty & (state==IDLE | last cycle of STOP).
  - This output is combinational.
  - It is never asserted when fifo_empty=1, so no pop is ever ignored by the FIFO.
- On the pop edge:
  - shift_reg <= fifo_data.
  - state <= START.
  - tx <= 0.
  - Baud counter cleared.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, bit0 first, each held CLKS_PER_BIT cycles. The bit index counts 0..7. After bit7, go to PARITY if PARITY_EN, otherwise STOP.
- PARITY: tx = ^data ^ PARITY_ODD, held CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - frame_done pulses in the final cycle.
  - At the final-cycle edge: if the pop condition holds, go to START (seamless back-to-back); otherwise go to IDLE.
- tx_enable deasserted mid-frame: the current frame completes unchanged; no further pop.
- tx_enable is sampled only at pop opportunities.
- busy = (state != IDLE).

## Timing
- Reset values:
  - tx=1, busy=0, frame_done=0, fifo_rd_en=0 (forced low while rst_n=0).
  - State IDLE; all counters 0.
- Reset mid-frame:
  - tx returns to 1 asynchronously.
  - The popped byte is discarded; there is no re-pop.
- Latency: fifo_rd_en high in cycle N, first start-bit cycle is N+1.
- tx and all state are registered.
- Frame length F = (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- frame_done occurs at cycle N+F.
- Back-to-back frames: fifo_rd_en pulses are exactly F cycles apart.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary.

## Structure
- Shared package uart_tx_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS = 8.
  - Line-level constants LINE_IDLE = 1 and START_LVL = 0.
- One sub-module, uart_bit_timer:
  - Inputs: clear, enable.
  - Output: bit_end pulse when the counter reaches CLKS_PER_BIT-1.
  - Parameterised by CLKS_PER_BIT.
- The top level holds the FSM, shift register, bit index, stop counter and parity accumulator.

## Test plan
- CLKS_PER_BIT=4, 8N1, FIFO holds 0xA5, tx_enable=1 → Required response:
  - One fifo_rd_en pulse.
  - tx, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - frame_done 40 cycles after the pop.
  - busy then falls.
- FIFO holds 0x00, 0xFF; STOP_BITS=2 → Required response:
  - Two pops exactly 44 cycles apart.
  - The second start bit immediately follows the 8 stop cycles, with no idle cycle.
  - The second frame's data bits are all 1.
- PARITY_EN=1 with byte 0x07 → parity bit 1 under even parity; 0 with PARITY_ODD=1. F=44.
- tx_enable dropped during DATA, FIFO still non-empty → Required response:
  - The current frame completes.
  - No further fifo_rd_en.
  - tx stays 1 and busy=0 until tx_enable returns.
  - The pop then occurs on the next cycle.
- rst_n asserted during bit 3 → Required response:
  - tx=1 and busy=0 immediately.
  - No fifo_rd_en while in reset.
  - After release, the next FIFO byte is sent as a complete frame.
- fifo_empty=1, tx_enable=1 for 100 cycles → fifo_rd_en never asserted; tx=1, busy=0, frame_done=0 throughout.
